mem_flasher: RTL and testbench
==============================

MEM_FLASHER -- requirements
Module: mem_flasher

Interface
REQ-001 Parameter WIDTH, default 32, data/address width; SHALL be 32 (four-byte packing is fixed).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  begin a load session; sampled in IDLE and DONE only.
REQ-005 rx_data  input  8  incoming byte stream.
REQ-006 rx_valid  input  1  rx_data holds a valid byte.
REQ-007 rx_ready  output  1  flasher accepts a byte this cycle.
REQ-008 flash_en  output  1  one-cycle write strobe to the memory flash port.
REQ-009 flash_addr  output  WIDTH  word index of the current write; memory uses bits [10:0].
REQ-010 flash_data  output  WIDTH  assembled word to write.
REQ-011 busy  output  1  high in every state except IDLE and DONE.
REQ-012 done  output  1  session complete; held high in DONE.

Function
REQ-013 A byte SHALL be accepted only on a cycle with rx_valid=1 and rx_ready=1.
REQ-014 rx_ready SHALL be 1 in LEN0, LEN1 and DATA, and 0 in IDLE, WRITE and DONE.
REQ-015 Stream format: 2-byte word count N, little-endian, then N*4 data bytes, little-endian per word.
REQ-016 States: IDLE, LEN0, LEN1, DATA, WRITE, DONE.
REQ-017 IDLE -> LEN0 on start=1; otherwise remain in IDLE.
REQ-018 LEN0 -> LEN1 on acceptance, latching N[7:0]; LEN1 latches N[15:8].
REQ-019 LEN1 -> DONE on acceptance if N=0; otherwise LEN1 -> DATA and clear word index and byte count.
REQ-020 DATA: the k-th accepted byte (k=0..3) SHALL be placed in word bits [8k+7:8k].
REQ-021 DATA -> WRITE on acceptance of byte k=3.
REQ-022 WRITE lasts exactly one cycle, with flash_en=1, flash_addr=word index (zero-extended), flash_data=assembled word.
REQ-023 flash_en SHALL be 1 only in WRITE; first strobe occurs the cycle after the 4th byte of a word is accepted.
REQ-024 WRITE -> DONE if word index = N-1; otherwise increment word index and return to DATA.
REQ-025 Word index is 16 bits; the module does not clamp N>2048; the memory wraps addresses modulo 2048.
REQ-026 DONE: done=1, busy=0; start=1 re-enters LEN0 and clears done in the same transition.
REQ-027 start asserted while busy SHALL be ignored.
REQ-028 Idle gaps (rx_valid=0) in any receiving state SHALL stall without state change.
REQ-029 flash_addr and flash_data SHALL hold their last values outside WRITE; flash_en=0 outside WRITE.
REQ-030 All outputs SHALL be registered or decoded from the state register only; rx_ready SHALL NOT depend combinationally on rx_valid.

Reset
REQ-031 On rst=0 at a clock edge: state=IDLE, flash_en=0, flash_addr=0, flash_data=0, busy=0, done=0, rx_ready=0, N=0, word index=0, byte count=0.
REQ-032 Reset mid-session SHALL abort the session: any partial word is discarded, and no flash_en occurs after the reset edge.

Structure
REQ-033 The state enum flasher_state_t SHALL live in a shared package alongside the existing load/store typedefs.
REQ-034 The byte-to-word shift/packing logic SHALL be one sub-module, byte_packer (8-bit in, 32-bit out, 2-bit byte counter, word_valid pulse).
REQ-035 The word index and N registers SHALL reuse the existing register module where an enable fits.

Verification
REQ-036 Stream 01 00 EF BE AD DE after start -> one flash_en, flash_addr=0, flash_data=DEADBEEF; done=1 on the following cycle.
REQ-037 N=3, words 11111111/22222222/33333333 with random rx_valid gaps -> three strobes at addresses 0,1,2 in order; rx_ready=0 during each WRITE cycle.
REQ-038 N=0 (00 00) -> no flash_en; DONE entered the cycle after the 2nd length byte is accepted.
REQ-039 rst=0 after 2 bytes of word 1 with N=4 -> state IDLE; no further strobes; a new session writes from address 0.
REQ-040 start pulsed during DATA -> ignored; start in DONE -> new session begins, done drops to 0.
REQ-041 N=2049 -> 2049 strobes; the final write has flash_addr=2048, and memory receives address bits [10:0]=0.

Source files
------------

// File: rtl/mem_flasher_pkg.sv
// Shared types for the memory flasher and the load/store path that sits
// next to it in the core.
package mem_flasher_pkg;

    localparam int WORD_W = 32;
    localparam int IDX_W  = 16;

    // Load/store access descriptors used by the LSU.
    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2
    } ls_size_t;

    typedef struct packed {
        logic        is_store;
        ls_size_t    size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ls_req_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } flasher_state_t;

    typedef struct packed {
        logic rx_ready;
        logic busy;
        logic done;
    } flasher_status_t;

    // Status flags that belong to a state; registered alongside the state.
    function automatic flasher_status_t status_of(flasher_state_t s);
        flasher_status_t st;
        st.rx_ready = (s == LEN0) || (s == LEN1) || (s == DATA);
        st.busy     = (s != IDLE) && (s != DONE);
        st.done     = (s == DONE);
        return st;
    endfunction

endpackage

// File: rtl/mem_flasher_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; the 4th byte completes
// the word combinationally so the caller can capture it on the same edge.
module byte_packer
    import mem_flasher_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [1:0]  byte_cnt;
    logic [23:0] low_bytes;

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt  <= 2'd0;
            // NOTE: the byte lanes are reset as well so a discarded partial
            // word never shows up as X on the packed output.
            low_bytes <= 24'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
        end else if (in_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    low_bytes[7:0]   <= in_data;
                2'd1:    low_bytes[15:8]  <= in_data;
                2'd2:    low_bytes[23:16] <= in_data;
                default: ;
            endcase
        end
    end

    assign word       = {in_data, low_bytes};
    assign word_valid = in_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/mem_flasher_enable_reg.sv
// Generic register with load enable and synchronous active-low reset to zero.
module enable_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_flasher.sv
// Receives a length-prefixed byte stream and writes it word by word through
// a single-cycle flash strobe.
module mem_flasher
    import mem_flasher_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             flash_en,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             busy,
    output logic             done
);

    flasher_state_t  state;
    flasher_status_t status;

    logic              accept;
    logic [7:0]        n_lo;
    logic [7:0]        n_hi;
    logic [IDX_W-1:0]  n_words;
    logic [IDX_W-1:0]  word_idx;
    logic [IDX_W-1:0]  idx_d;
    logic              idx_en;
    logic              last_word;
    logic [WORD_W-1:0] packed_word;
    logic              word_valid;

    assign accept    = rx_valid && rx_ready;
    assign n_words   = {n_hi, n_lo};
    assign last_word = (word_idx == n_words - 16'd1);

    assign rx_ready = status.rx_ready;
    assign busy     = status.busy;
    assign done     = status.done;

    enable_reg #(.W(8)) u_n_lo (
        .clk (clk),
        .rst (rst),
        .en  ((state == LEN0) && accept),
        .d   (rx_data),
        .q   (n_lo)
    );

    enable_reg #(.W(8)) u_n_hi (
        .clk (clk),
        .rst (rst),
        .en  ((state == LEN1) && accept),
        .d   (rx_data),
        .q   (n_hi)
    );

    // Cleared when the length completes, bumped after every non-final write.
    assign idx_en = ((state == LEN1) && accept) || ((state == WRITE) && !last_word);
    assign idx_d  = (state == WRITE) ? word_idx + 16'd1 : 16'd0;

    enable_reg #(.W(IDX_W)) u_word_idx (
        .clk (clk),
        .rst (rst),
        .en  (idx_en),
        .d   (idx_d),
        .q   (word_idx)
    );

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      ((state == LEN1) && accept),
        .in_valid   ((state == DATA) && accept),
        .in_data    (rx_data),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            status     <= status_of(IDLE);
            flash_en   <= 1'b0;
            flash_addr <= '0;
            flash_data <= '0;
        end else begin
            // NOTE: flash_en defaults low every cycle, so it can only ever be
            // raised for the single cycle spent in WRITE.
            flash_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= LEN0;
                        status <= status_of(LEN0);
                    end
                end
                LEN0: begin
                    if (accept) begin
                        state  <= LEN1;
                        status <= status_of(LEN1);
                    end
                end
                LEN1: begin
                    if (accept) begin
                        if ({rx_data, n_lo} == 16'd0) begin
                            state  <= DONE;
                            status <= status_of(DONE);
                        end else begin
                            state  <= DATA;
                            status <= status_of(DATA);
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        state      <= WRITE;
                        status     <= status_of(WRITE);
                        flash_en   <= 1'b1;
                        flash_addr <= WIDTH'(word_idx);
                        flash_data <= WIDTH'(packed_word);
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        state  <= DONE;
                        status <= status_of(DONE);
                    end else begin
                        state  <= DATA;
                        status <= status_of(DATA);
                    end
                end
                default: begin
                    state  <= IDLE;
                    status <= status_of(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_flasher.sv
// Self-checking bench for mem_flasher: table vectors, hand-built corner
// sequences and randomized sessions compared against a word-list model.
module tb_mem_flasher;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        flash_en;
    logic [31:0] flash_addr;
    logic [31:0] flash_data;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    // Every observed strobe as {addr, data}.
    logic [63:0] wq[$];

    mem_flasher #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .flash_en   (flash_en),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (flash_en === 1'b1) begin
            wq.push_back({flash_addr, flash_data});
            check("rx_ready_low_in_write", 64'(rx_ready), 64'(0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            step();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 20; t++) begin
            if (rx_ready === 1'b1) begin
                step();
                rx_valid = 1'b0;
                return;
            end
            step();
        end
        rx_valid = 1'b0;
        check("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_done(input int bound, input string name);
        for (int t = 0; t < bound; t++) begin
            if (done === 1'b1) return;
            step();
        end
        check({name, "_timeout"}, 64'(0), 64'(1));
    endtask

    // Reference: word i of the list lands at address i, in order.
    task automatic run_words(input logic [31:0] ws[$], input int gap, input string tag);
        int n;
        n = ws.size();
        wq.delete();
        pulse_start();
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(ws[i][8*k +: 8], gap);
            end
        end
        wait_done(20, tag);
        step();
        check({tag, "_count"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check({tag, "_write"}, wq[i], {32'(i), ws[i]});
        end
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    typedef struct {
        logic [111:0] stream;
        int           nbytes;
        int           exp_writes;
        logic [31:0]  exp_addr;
        logic [31:0]  exp_data;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[4];
        logic [31:0] ws[$];

        vecs[0] = '{112'h0000_DEAD_BEEF_0001, 6, 1, 32'h0, 32'hDEADBEEF};
        vecs[1] = '{112'h0000, 2, 0, 32'h0, 32'hDEADBEEF};
        vecs[2] = '{112'h5566_7788_1122_3344_0002, 10, 2, 32'h1, 32'h55667788};
        vecs[3] = '{112'h1234_5678_0000_0002_0000_0001_0003, 14, 3, 32'h2, 32'h12345678};

        rst      = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) step();
        check("rst_busy",       64'(busy),       64'(0));
        check("rst_done",       64'(done),       64'(0));
        check("rst_rx_ready",   64'(rx_ready),   64'(0));
        check("rst_flash_en",   64'(flash_en),   64'(0));
        check("rst_flash_addr", 64'(flash_addr), 64'(0));
        check("rst_flash_data", 64'(flash_data), 64'(0));
        rst = 1'b1;
        step();
        check("idle_no_start", 64'(busy), 64'(0));

        // Table vectors; the N=0 entry also checks that addr/data are held.
        for (int v = 0; v < 4; v++) begin
            wq.delete();
            pulse_start();
            for (int b = 0; b < vecs[v].nbytes; b++) begin
                send_byte(vecs[v].stream[8*b +: 8], 0);
            end
            wait_done(20, "vec");
            step();
            check($sformatf("vec%0d_writes", v), 64'(wq.size()), 64'(vecs[v].exp_writes));
            check($sformatf("vec%0d_addr", v), 64'(flash_addr), 64'(vecs[v].exp_addr));
            check($sformatf("vec%0d_data", v), 64'(flash_data), 64'(vecs[v].exp_data));
            check($sformatf("vec%0d_done", v), 64'(done), 64'(1));
            check($sformatf("vec%0d_rx_ready", v), 64'(rx_ready), 64'(0));
        end

        // Strobe timing: the cycle after the 4th data byte, then done.
        wq.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        check("t1_strobe", 64'(flash_en),   64'(1));
        check("t1_addr",   64'(flash_addr), 64'(0));
        check("t1_data",   64'(flash_data), 64'(32'hDEADBEEF));
        check("t1_not_done_yet", 64'(done), 64'(0));
        step();
        check("t1_strobe_off", 64'(flash_en), 64'(0));
        check("t1_done",       64'(done),     64'(1));
        check("t1_one_write",  64'(wq.size()), 64'(1));

        // Zero-length session goes straight to DONE.
        wq.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("n0_done",     64'(done),     64'(1));
        check("n0_busy",     64'(busy),     64'(0));
        check("n0_rx_ready", 64'(rx_ready), 64'(0));
        step();
        check("n0_no_write", 64'(wq.size()), 64'(0));

        ws = {32'h11111111, 32'h22222222, 32'h33333333};
        run_words(ws, 3, "gaps3");

        // start held during DATA is ignored; start in DONE restarts.
        wq.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0A, 0);
        send_byte(8'h0B, 0);
        start = 1'b1;
        send_byte(8'h0C, 1);
        send_byte(8'h0D, 1);
        send_byte(8'h1A, 1);
        start = 1'b0;
        check("sd_busy", 64'(busy), 64'(1));
        check("sd_done", 64'(done), 64'(0));
        send_byte(8'h1B, 0);
        send_byte(8'h1C, 0);
        send_byte(8'h1D, 0);
        wait_done(20, "sd");
        step();
        check("sd_count", 64'(wq.size()), 64'(2));
        if (wq.size() == 2) begin
            check("sd_w0", wq[0], {32'h0, 32'h0D0C0B0A});
            check("sd_w1", wq[1], {32'h1, 32'h1D1C1B1A});
        end
        pulse_start();
        check("restart_done",     64'(done),     64'(0));
        check("restart_busy",     64'(busy),     64'(1));
        check("restart_rx_ready", 64'(rx_ready), 64'(1));
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("restart_n0_done", 64'(done), 64'(1));

        // Reset in the middle of the second word of a 4-word session.
        wq.delete();
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mr_busy",       64'(busy),       64'(0));
        check("mr_done",       64'(done),       64'(0));
        check("mr_rx_ready",   64'(rx_ready),   64'(0));
        check("mr_flash_addr", 64'(flash_addr), 64'(0));
        check("mr_flash_data", 64'(flash_data), 64'(0));
        rx_valid = 1'b1;
        repeat (8) begin
            rx_data = 8'($urandom);
            step();
        end
        rx_valid = 1'b0;
        step();
        check("mr_writes", 64'(wq.size()), 64'(1));
        if (wq.size() >= 1) check("mr_w0", wq[0], {32'h0, 32'h44332211});
        check("mr_idle", 64'(busy), 64'(0));
        ws = {32'hCAFEF00D};
        run_words(ws, 0, "post_rst");

        // Randomized sessions with random idle gaps.
        for (int s = 0; s < 20; s++) begin
            int n;
            n = int'($urandom_range(6, 1));
            ws.delete();
            for (int i = 0; i < n; i++) ws.push_back($urandom);
            run_words(ws, 3, "rand");
        end

        // Lengths past the memory depth are not clamped.
        ws.delete();
        for (int i = 0; i < 2049; i++) ws.push_back($urandom);
        run_words(ws, 0, "n2049");
        check("n2049_last_addr", 64'(flash_addr), 64'(2048));
        check("n2049_mem_addr",  64'(flash_addr[10:0]), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
